// File: rtl/ysyx_24070014_mem_pkg.sv
// rtl/ysyx_24070014_mem_pkg.sv - shared constants and types for the memory-port arbiter
package ysyx_24070014_mem_pkg;

  localparam int WORD_LEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24070014_arb_pick.sv
// rtl/ysyx_24070014_arb_pick.sv - combinational grant picker; YSYX_24070014_ARB_RR_EN selects round-robin
module ysyx_24070014_arb_pick (
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  input  logic last_owner_i,
  output logic grant_ifu_o,
  output logic grant_lsu_o
);
  import ysyx_24070014_mem_pkg::*;

`ifdef YSYX_24070014_ARB_RR_EN
  // On a conflict the requester that did not win last time goes first
  always_comb begin
    grant_lsu_o = lsu_valid_i && (!ifu_valid_i || (last_owner_i == OWN_IFU));
    grant_ifu_o = ifu_valid_i && (!lsu_valid_i || (last_owner_i == OWN_LSU));
  end
`else
  // Fixed priority: a pending data access always beats instruction fetch
  always_comb begin
    grant_lsu_o = lsu_valid_i;
    grant_ifu_o = ifu_valid_i && !lsu_valid_i;
  end

  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/ysyx_24070014_mem_arbiter.sv
// rtl/ysyx_24070014_mem_arbiter.sv - IFU/LSU arbiter for the single memory port; YSYX_24070014_ARB_RR_EN enables round-robin
module ysyx_24070014_mem_arbiter #(
  parameter int WORD_LEN = ysyx_24070014_mem_pkg::WORD_LEN,
  parameter int MASK_LEN = WORD_LEN / 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [WORD_LEN-1:0] ifu_addr,
  output logic                ifu_resp_valid,
  output logic [WORD_LEN-1:0] ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [WORD_LEN-1:0] lsu_addr,
  input  logic                lsu_wen,
  input  logic [WORD_LEN-1:0] lsu_wdata,
  input  logic [MASK_LEN-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [WORD_LEN-1:0] lsu_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  output logic [MASK_LEN-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [WORD_LEN-1:0] mem_resp_data,
  output logic                owner,
  output logic                protocol_err
);
  import ysyx_24070014_mem_pkg::*;

  state_e              state_q;
  logic                owner_q;
  logic                err_q;
  logic                req_valid_q;
  logic [WORD_LEN-1:0] addr_q;
  logic                wen_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic [MASK_LEN-1:0] wmask_q;
  logic                last_owner;
  logic                grant_ifu;
  logic                grant_lsu;
  logic                idle;
  logic                resp_done;

  ysyx_24070014_arb_pick u_pick (
    .ifu_valid_i  (ifu_req_valid),
    .lsu_valid_i  (lsu_req_valid),
    .last_owner_i (last_owner),
    .grant_ifu_o  (grant_ifu),
    .grant_lsu_o  (grant_lsu)
  );

`ifdef YSYX_24070014_ARB_RR_EN
  logic rr_q;

  // Remember the last winner; reset value makes IFU win the first conflict
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q <= OWN_LSU;
    end else if (idle && grant_lsu) begin
      rr_q <= OWN_LSU;
    end else if (idle && grant_ifu) begin
      rr_q <= OWN_IFU;
    end
  end

  assign last_owner = rr_q;
`else
  assign last_owner = owner_q;
`endif

  assign idle          = (state_q == IDLE);
  assign resp_done     = (state_q == WAIT) && mem_resp_valid;
  assign ifu_req_ready = idle && grant_ifu;
  assign lsu_req_ready = idle && grant_lsu;

  // Main sequencer: capture the winner, present it to memory, await the response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IFU;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_resp_valid) err_q <= 1'b1;
          if (grant_lsu) begin
            addr_q      <= lsu_addr;
            wen_q       <= lsu_wen;
            wdata_q     <= lsu_wdata;
            wmask_q     <= lsu_wen ? lsu_wmask : '0;
            owner_q     <= OWN_LSU;
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end else if (grant_ifu) begin
            addr_q      <= ifu_addr;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            owner_q     <= OWN_IFU;
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_resp_valid) err_q <= 1'b1;
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifu_resp_valid = resp_done && (owner_q == OWN_IFU);
  assign lsu_resp_valid = resp_done && (owner_q == OWN_LSU);
  assign ifu_resp_data  = mem_resp_data;
  assign lsu_resp_data  = mem_resp_data;
  assign mem_req_valid  = req_valid_q;
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign owner          = owner_q;
  assign protocol_err   = err_q;

endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// tb/tb_ysyx_24070014_mem_arbiter.sv - directed scoreboard bench for the memory-port arbiter
module tb_ysyx_24070014_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_resp_data;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_resp_data;
  logic [3:0]  mem_wmask;
  logic        owner, protocol_err;

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;

`ifdef YSYX_24070014_ARB_RR_EN
  localparam bit FIRST_LSU = 1'b0;
`else
  localparam bit FIRST_LSU = 1'b1;
`endif

  always #5 clk = ~clk;

  ysyx_24070014_mem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_data  (ifu_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_data  (lsu_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .owner          (owner),
    .protocol_err   (protocol_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input bit lsu, input logic [31:0] addr, input logic wen,
                      input logic [31:0] wdata, input logic [3:0] wmask, input logic [31:0] rdata);
    txn_t t;
    t.lsu = lsu; t.addr = addr; t.wen = wen; t.wdata = wdata;
    t.wmask = wen ? wmask : 4'h0;
    t.rdata = rdata;
    sb.push_back(t);
  endtask

  // Called after the grant-cycle sample; ends at the start of the cycle after the response
  task automatic run_txn(input int stall);
    txn_t e;
    e = sb[0];
    step();
    if (e.lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      smp();
      check("stall_req_valid", mem_req_valid, 1);
      check("stall_addr", mem_addr, e.addr);
      if (e.wen) check("stall_wdata", mem_wdata, e.wdata);
      check("stall_readies", {ifu_req_ready, lsu_req_ready}, 0);
      step();
    end
    mem_req_ready = 1'b1;
    smp();
    check("req_valid", mem_req_valid, 1);
    check("req_addr", mem_addr, e.addr);
    check("req_wen", mem_wen, e.wen);
    check("req_wmask", mem_wmask, e.wmask);
    if (e.wen) check("req_wdata", mem_wdata, e.wdata);
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = e.rdata;
    smp();
    check("wait_req_valid", mem_req_valid, 0);
    check("ifu_resp_valid", ifu_resp_valid, !e.lsu);
    check("lsu_resp_valid", lsu_resp_valid, e.lsu);
    if (!e.lsu) check("ifu_resp_data", ifu_resp_data, e.rdata);
    if (e.lsu && !e.wen) check("lsu_resp_data", lsu_resp_data, e.rdata);
    check("owner", owner, e.lsu);
    check("wait_readies", {ifu_req_ready, lsu_req_ready}, 0);
    step();
    mem_resp_valid = 1'b0;
    void'(sb.pop_front());
  endtask

  initial begin
    reset = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    step(); step();
    smp();
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_owner", owner, 0);
    check("rst_err", protocol_err, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_fields", {mem_addr, mem_wdata[27:0], mem_wmask}, 0);
    step();
    reset = 1'b1;

    // Conflict: LSU store and IFU fetch raised together
    step();
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    if (FIRST_LSU) begin
      push(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 32'h0);
      push(0, 32'h8000_0004, 0, 32'h0, 4'h0, 32'h0000_0013);
    end else begin
      push(0, 32'h8000_0004, 0, 32'h0, 4'h0, 32'h0000_0013);
      push(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 32'h0);
    end
    smp();
    check("conflict_lsu_ready", lsu_req_ready, FIRST_LSU);
    check("conflict_ifu_ready", ifu_req_ready, !FIRST_LSU);
    run_txn(0);
    smp();
    check("second_lsu_ready", lsu_req_ready, !FIRST_LSU);
    check("second_ifu_ready", ifu_req_ready, FIRST_LSU);
    run_txn(0);
    lsu_wen = 0;

    // Lone IFU read
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    push(0, 32'h8000_0000, 0, 32'h0, 4'h0, 32'h0000_0297);
    smp();
    check("lone_ifu_ready", ifu_req_ready, 1);
    run_txn(0);

    // LSU load with a stray mask: memory must see an all-zero mask
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_wmask = 4'hF;
    push(1, 32'h8000_2000, 0, 32'h0, 4'h0, 32'hCAFE_F00D);
    smp();
    check("load_ready", lsu_req_ready, 1);
    run_txn(0);

    // Backpressure: store held off by the memory for 5 cycles
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 1;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b0011;
    push(1, 32'h8000_3000, 1, 32'h1234_5678, 4'b0011, 32'h0);
    smp();
    check("bp_ready", lsu_req_ready, 1);
    run_txn(5);
    lsu_wen = 0;

    // Spurious response while idle
    mem_resp_valid = 1; mem_resp_data = 32'hBAD0_BAD0;
    smp();
    check("spur_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    step();
    mem_resp_valid = 0;
    smp();
    check("spur_err", protocol_err, 1);

    // Reset while an LSU load waits for its response
    step();
    lsu_req_valid = 1; lsu_addr = 32'h8000_4000; lsu_wen = 0;
    smp();
    check("drop_ready", lsu_req_ready, 1);
    step();
    lsu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    smp();
    check("drop_owner_before", owner, 1);
    check("err_sticky", protocol_err, 1);
    step();
    reset = 0;
    step();
    reset = 1;
    smp();
    check("drop_req_valid", mem_req_valid, 0);
    check("drop_owner", owner, 0);
    check("drop_err_cleared", protocol_err, 0);
    step();
    mem_resp_valid = 1; mem_resp_data = 32'h5555_AAAA;
    smp();
    check("late_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    step();
    mem_resp_valid = 0;
    smp();
    check("late_err", protocol_err, 1);
    step();
    reset = 0;
    step();
    reset = 1;

    // New fetch after reset completes normally
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
    push(0, 32'h8000_0008, 0, 32'h0, 4'h0, 32'h0010_0073);
    smp();
    check("post_rst_ready", ifu_req_ready, 1);
    check("post_rst_err", protocol_err, 0);
    run_txn(0);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_24070014_mem_arbiter.md
Name: ysyx_24070014_mem_arbiter

Overview:
Two-requester arbiter and sequencer that shares the core's single main-memory port between instruction fetch (IFU) and load/store (LSU). It sits between the core datapath and the memory interface, which is currently exposed as top-level signals. It replaces direct single-cycle access with a valid/ready request plus response-valid handshake, and allows one outstanding transaction at a time. Default policy is fixed priority, with LSU ahead of IFU so that a data access in flight is not starved.

Parameters:
WORD_LEN, 32, address and data width in bits
MASK_LEN, WORD_LEN/8, byte write-mask width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  WORD_LEN  fetch address (the PC)
ifu_resp_valid  out  1  fetch data valid, one-cycle pulse
ifu_resp_data  out  WORD_LEN  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  WORD_LEN  data address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  WORD_LEN  store data
lsu_wmask  in  MASK_LEN  store byte enables
lsu_resp_valid  out  1  load data or store acknowledge, one-cycle pulse
lsu_resp_data  out  WORD_LEN  load data (don't-care on stores)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  WORD_LEN  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  WORD_LEN  registered write data
mem_wmask  out  MASK_LEN  registered mask; all zero on reads
mem_resp_valid  in  1  memory response, single-cycle pulse
mem_resp_data  in  WORD_LEN  read data
owner  out  1  0 = IFU, 1 = LSU; holds the last grant
protocol_err  out  1  sticky protocol-violation flag

Behaviour:
- FSM states are IDLE, REQ and WAIT. Reset (reset==0 at posedge) forces IDLE and sets owner=0, protocol_err=0, mem_req_valid=0 and mem_wen=0. Reset clears mem_addr, mem_wdata and mem_wmask to 0.
- IDLE:
  - Grant logic is combinational. The winner's *_req_ready=1 only in IDLE; the loser's ready=0.
  - On winner valid&ready, capture the winner's addr/wen/wdata/wmask into the mem_* registers. IFU grants force wen=0 and wmask=0. Set owner, then go to REQ.
- REQ: mem_req_valid=1. On mem_req_ready=1, go to WAIT. Held fields stay stable while waiting.
- WAIT:
  - On mem_resp_valid=1, pulse the owner's *_resp_valid for the same cycle; *_resp_data = mem_resp_data, passed through combinationally. Go to IDLE.
  - The non-owner's resp_valid stays 0.
- Latency: grant at cycle 0, mem_req_valid at cycle 1, earliest response at cycle 2 (a 0-wait memory responds the cycle after acceptance). The next grant is possible the cycle after the response, so back-to-back throughput is 1 transaction per 3 cycles.
- Stores also wait for mem_resp_valid, which serves as the write acknowledge.
- Simultaneous requests: LSU wins (fixed priority) unless the optional feature is enabled.
- Protocol violations set protocol_err=1 until reset; state is unchanged:
  - mem_resp_valid in IDLE or REQ: response ignored, no *_resp_valid pulse.
- Reset mid-operation drops the outstanding transaction with no response pulse. A late mem_resp_valid that then arrives in IDLE sets protocol_err.
- Requesters must hold valid and payload stable until ready. The arbiter does not check this.

Optional Feature:
YSYX_24070014_ARB_RR_EN: when defined, a round-robin register is added. When both requesters are valid in IDLE, the requester not granted last wins; the register is reset so IFU wins the first conflict. A lone requester always wins. Without the macro, fixed priority LSU > IFU applies and no extra state is added.

Decomposition:
- Package ysyx_24070014_mem_pkg holds:
  - the WORD_LEN constant (32)
  - the state enum {IDLE, REQ, WAIT}
  - the owner encoding constants OWN_IFU=0 and OWN_LSU=1
- One natural sub-module, ysyx_24070014_arb_pick: a combinational picker taking both valids and last_owner, and returning grant_ifu/grant_lsu. It hosts the macro-dependent policy.

Test Plan:
- Lone IFU read: ifu_addr=0x80000000, memory 0-wait returning 0x00000297 → ifu_resp_valid pulse exactly 2 cycles after grant with data 0x00000297, owner=0, lsu_resp_valid never set.
- Conflict: both valid, LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=4'b1111 → LSU granted first, mem_wen=1 with those values; IFU granted the cycle after the LSU ack. With RR_EN and reset state, IFU goes first instead.
- Backpressure: mem_req_ready held 0 for 5 cycles → mem_req_valid stays 1 and mem_addr/mem_wdata stay stable; WAIT is entered on the cycle ready=1; both *_req_ready stay 0 throughout.
- Spurious response: mem_resp_valid=1 in IDLE → no *_resp_valid pulse, protocol_err=1 and sticky until reset=0.
- Reset in WAIT: reset=0 for 1 cycle → FSM in IDLE, mem_req_valid=0, owner=0, no resp pulse; a new IFU request after reset completes normally.
